// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between writeback units.
// It also keeps a busy scoreboard of destination registers and reports RAW hazards to issue.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [5*N_REQ-1:0]    req_rd,
  input  logic [XLEN*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rf_we,
  output logic [4:0]            rf_wa,
  output logic [XLEN-1:0]       rf_wd,
  input  logic                  sb_set,
  input  logic [4:0]            sb_set_rd,
  input  logic [4:0]            chk_ra1,
  input  logic [4:0]            chk_ra2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [31:0]           busy_mask
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] rr_ptr_next;
  logic [N_REQ-1:0] grant;
  logic             handshake;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic [31:0]      busy_reg;
  logic [31:0]      busy_next;
  logic             rf_we_reg;
  logic [4:0]       rf_wa_reg;
  logic [XLEN-1:0]  rf_wd_reg;

  logic [4:0]      rd_arr   [N_REQ];
  logic [XLEN-1:0] data_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign rd_arr[gi]   = req_rd[gi*5 +: 5];
      assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    int idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
    if (!rst_n) begin
      grant = '0;
      found = 1'b0;
    end
    handshake = found;
  end

  assign req_ready   = grant;
  assign sel_rd      = rd_arr[grant_idx];
  assign sel_data    = data_arr[grant_idx];
  assign rr_ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // A new producer issued in the same cycle outranks the retiring write.
  always_comb begin
    busy_next = busy_reg;
    if (handshake && sel_rd != 5'd0)
      busy_next[sel_rd] = 1'b0;
    if (sb_set && sb_set_rd != 5'd0)
      busy_next[sb_set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      busy_reg   <= '0;
      rf_we_reg  <= 1'b0;
      rf_wa_reg  <= '0;
      rf_wd_reg  <= '0;
    end else begin
      busy_reg  <= busy_next;
      rf_we_reg <= 1'b0;
      if (handshake) begin
        rr_ptr_reg <= rr_ptr_next;
        rf_we_reg  <= (sel_rd != 5'd0);
        rf_wa_reg  <= sel_rd;
        rf_wd_reg  <= sel_data;
      end
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_wa     = rf_wa_reg;
  assign rf_wd     = rf_wd_reg;
  assign busy_mask = busy_reg;

  // The in-flight term covers the write sitting in the output register.
  assign hazard1 = (chk_ra1 != 5'd0) &&
                   (busy_reg[chk_ra1] || (rf_we_reg && rf_wa_reg == chk_ra1));
  assign hazard2 = (chk_ra2 != 5'd0) &&
                   (busy_reg[chk_ra2] || (rf_we_reg && rf_wa_reg == chk_ra2));

endmodule
